// File: rtl/can_tail_tx.sv
`default_nettype none
// ============================================================================
//  Module      : can_tail_tx
//  Description : Transmit-side generator for the fixed tail of a CAN
//                data/remote frame (CRC delimiter, ACK slot, ACK delimiter,
//                EOF, intermission). Checks RX against every bit it drives
//                and, on a violation, sends an active error frame (error
//                flag followed by error delimiter).
//  Revision    : 1.0  - initial release
// ============================================================================
//  All state changes happen on the SP rising edge. The edge that enters a
//  state drives TX for that state's bit; the following edge samples RX for
//  that bit and decides the next state.
//  All length parameters must be in 1..15 (4-bit bit counter).
// ============================================================================
module can_tail_tx #(
    parameter int EOF_LEN    = 7,
    parameter int IFS_LEN    = 3,
    parameter int EFLAG_LEN  = 6,
    parameter int EDELIM_LEN = 8
) (
    input  logic SP,
    input  logic reset,
    input  logic START,
    input  logic ROLE,
    input  logic CRC_OK,
    input  logic RX,
    output logic TX,
    output logic BUSY,
    output logic DONE,
    output logic ERR_ACTIVE,
    output logic ACK_Error,
    output logic BIT_Error,
    output logic CRC_Error
);

    // Terminal counter values: a state holding N bits leaves when the
    // counter reaches N-1 on its sampling edge.
    localparam logic [3:0] c_EOF_LAST    = 4'(EOF_LEN - 1);
    localparam logic [3:0] c_IFS_LAST    = 4'(IFS_LEN - 1);
    localparam logic [3:0] c_EFLAG_LAST  = 4'(EFLAG_LEN - 1);
    localparam logic [3:0] c_EDELIM_LAST = 4'(EDELIM_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CRC_DELIM = 3'd1,
        S_ACK_SLOT  = 3'd2,
        S_ACK_DELIM = 3'd3,
        S_EOF       = 3'd4,
        S_IFS       = 3'd5,
        S_ERR_FLAG  = 3'd6,
        S_ERR_DELIM = 3'd7
    } state_t;

    state_t     r_state;
    logic [3:0] r_cnt;

    logic w_bit_err;
    logic w_ack_err;
    logic w_crc_err;
    logic w_abort;

    // Classify the bit just sampled: which (if any) violation it represents.
    always_comb begin
        w_bit_err = 1'b0;
        w_ack_err = 1'b0;
        w_crc_err = 1'b0;
        case (r_state)
            S_CRC_DELIM: begin
                w_bit_err = ~RX;
            end
            S_ACK_SLOT: begin
                // Transmitter sends recessive and needs someone to ACK.
                // Receiver with good CRC drives dominant and must read it back.
                // Receiver with bad CRC sends recessive and ignores the bus.
                if (TX && ROLE) begin
                    w_ack_err = RX;
                end else if (!TX) begin
                    w_bit_err = RX;
                end
            end
            S_ACK_DELIM: begin
                w_bit_err = ~RX;
                // A bad receiver CRC is reported after the ACK delimiter,
                // unless the delimiter itself was already a bit error.
                w_crc_err = RX & ~ROLE & ~CRC_OK;
            end
            S_EOF: begin
                w_bit_err = ~RX;
            end
            default: begin
                w_bit_err = 1'b0;
            end
        endcase
    end

    assign w_abort = w_bit_err | w_ack_err | w_crc_err;

    // Tail / error-frame sequencer with registered bus drive and status.
    always_ff @(posedge SP) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            TX         <= 1'b1;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ERR_ACTIVE <= 1'b0;
            ACK_Error  <= 1'b1;
            BIT_Error  <= 1'b1;
            CRC_Error  <= 1'b1;
        end else begin
            DONE <= 1'b0;
            if (w_abort) begin
                // Any violation starts the active error flag on this edge.
                if (w_bit_err) BIT_Error <= 1'b0;
                if (w_ack_err) ACK_Error <= 1'b0;
                if (w_crc_err) CRC_Error <= 1'b0;
                r_state    <= S_ERR_FLAG;
                TX         <= 1'b0;
                ERR_ACTIVE <= 1'b1;
                r_cnt      <= 4'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (START) begin
                            r_state   <= S_CRC_DELIM;
                            TX        <= 1'b1;
                            BUSY      <= 1'b1;
                            ACK_Error <= 1'b1;
                            BIT_Error <= 1'b1;
                            CRC_Error <= 1'b1;
                            r_cnt     <= 4'd0;
                        end
                    end
                    S_CRC_DELIM: begin
                        r_state <= S_ACK_SLOT;
                        // Only a receiver that accepted the CRC drives the ACK.
                        TX      <= ~(~ROLE & CRC_OK);
                    end
                    S_ACK_SLOT: begin
                        r_state <= S_ACK_DELIM;
                        TX      <= 1'b1;
                    end
                    S_ACK_DELIM: begin
                        r_state <= S_EOF;
                        r_cnt   <= 4'd0;
                    end
                    S_EOF: begin
                        if (r_cnt == c_EOF_LAST) begin
                            // Last EOF bit read back recessive: frame is valid.
                            DONE    <= 1'b1;
                            r_state <= S_IFS;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    S_IFS: begin
                        // A dominant bit in intermission is the next frame's
                        // start of frame, not an error: just stop early.
                        if (!RX || (r_cnt == c_IFS_LAST)) begin
                            r_state <= S_IDLE;
                            BUSY    <= 1'b0;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    S_ERR_FLAG: begin
                        if (r_cnt == c_EFLAG_LAST) begin
                            r_state <= S_ERR_DELIM;
                            TX      <= 1'b1;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    S_ERR_DELIM: begin
                        if (r_cnt == c_EDELIM_LAST) begin
                            r_state    <= S_IDLE;
                            BUSY       <= 1'b0;
                            ERR_ACTIVE <= 1'b0;
                            r_cnt      <= 4'd0;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    default: begin
                        r_state    <= S_IDLE;
                        TX         <= 1'b1;
                        BUSY       <= 1'b0;
                        ERR_ACTIVE <= 1'b0;
                        r_cnt      <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/can_tail_tx.md
Name: can_tail_tx

Overview:
- Transmit-side generator for the fixed-form tail of a CAN data/remote frame: CRC delimiter, ACK slot, ACK delimiter, EOF and intermission.
- Runs in both roles:
  - Transmitter role: the node sends the ACK slot recessive and expects a dominant ACK from the bus.
  - Receiver role: the node drives a dominant ACK when the CRC is good.
- Monitors RX on every bit it sends. On any violation it aborts and emits an active error frame: error flag, then error delimiter.
- Starts when the CRC-sequence serializer finishes. It is the sending counterpart of the form-error checker in the receive path.

Parameters:
- EOF_LEN, 7, number of recessive EOF bits.
- IFS_LEN, 3, number of intermission bits.
- EFLAG_LEN, 6, number of dominant error-flag bits.
- EDELIM_LEN, 8, number of recessive error-delimiter bits.

Ports:
- SP  input  1  clock; one rising edge per bit at the sample point.
- reset  input  1  synchronous, active-high reset.
- START  input  1  request to begin the tail; sampled on SP.
- ROLE  input  1  1 = transmitter, 0 = receiver.
- CRC_OK  input  1  receiver CRC result; must be stable from START through the ACK delimiter.
- RX  input  1  sampled bus level; 0 = dominant.
- TX  output  1  bus drive for the next bit; 0 = dominant.
- BUSY  output  1  high while the tail or error frame is in progress.
- DONE  output  1  one-SP pulse: frame validated at the end of EOF.
- ERR_ACTIVE  output  1  high while an error flag or error delimiter is being sent.
- ACK_Error  output  1  active-low, sticky: no ACK seen (transmitter role).
- BIT_Error  output  1  active-low, sticky: RX differed from TX.
- CRC_Error  output  1  active-low, sticky: receiver CRC_OK was 0.

Behaviour:
- Reset, and all state changes, take effect on the SP rising edge.
- Reset values:
  - State IDLE, TX=1, BUSY=0, DONE=0, ERR_ACTIVE=0.
  - ACK_Error=1, BIT_Error=1, CRC_Error=1, counter=0.
- Reset has priority over everything, including mid-frame and mid-error-frame; the block is in IDLE after that edge.
- Timing convention:
  - The edge that enters a state sets TX for that state's bit.
  - The next edge samples RX for that bit and transitions.
- IDLE:
  - On START=1: go to CRC_DELIM, TX<=1, BUSY<=1, all three error flags <=1.
  - START is ignored whenever BUSY=1.
- CRC_DELIM:
  - RX=0: BIT_Error<=0, go to ERR_FLAG.
  - Else go to ACK_SLOT, with TX<=0 if ROLE=0 and CRC_OK=1, otherwise TX<=1.
- ACK_SLOT:
  - TX=1 (transmitter role) and RX=1: ACK_Error<=0, go to ERR_FLAG.
  - TX=0 (receiver role) and RX=1: BIT_Error<=0, go to ERR_FLAG.
  - TX=1 in receiver role (bad CRC): RX is not checked.
  - Otherwise go to ACK_DELIM, TX<=1.
- ACK_DELIM:
  - RX=0: BIT_Error<=0, go to ERR_FLAG.
  - Else, if ROLE=0 and CRC_OK=0: CRC_Error<=0, go to ERR_FLAG.
  - Else go to EOF, counter<=0.
- EOF, TX=1:
  - RX=0: BIT_Error<=0, go to ERR_FLAG.
  - When counter=EOF_LEN-1 with RX=1: DONE<=1 for one SP, go to IFS, counter<=0.
  - Otherwise counter+1.
- IFS, TX=1:
  - RX=0 ends IFS early: go to IDLE, BUSY<=0, no error flag set.
  - When counter=IFS_LEN-1: go to IDLE, BUSY<=0.
- ERR_FLAG:
  - Entered with TX<=0, ERR_ACTIVE<=1, counter<=0. RX is not checked.
  - After EFLAG_LEN sampled bits, go to ERR_DELIM with TX<=1, counter<=0.
- ERR_DELIM:
  - TX=1, RX is not checked.
  - After EDELIM_LEN bits, go to IDLE with BUSY<=0 and ERR_ACTIVE<=0.
- Error flags stay low after the error frame until the next accepted START or reset.
- DONE is never asserted in a frame that enters ERR_FLAG.
- Latency with START accepted at edge k and no errors:
  - TX=1 at every edge.
  - DONE at edge k+3+EOF_LEN (k+10).
  - BUSY falls at edge k+3+EOF_LEN+IFS_LEN (k+13).
- Latency with an error detected at edge e:
  - TX=0 on edges e through e+EFLAG_LEN-1.
  - TX=1 from edge e+EFLAG_LEN.
  - IDLE at edge e+EFLAG_LEN+EDELIM_LEN (e+14).
- Counter is 4 bits wide; all length parameters must be ≤ 15.

Test Plan:
- Transmitter, good ACK: ROLE=1, START at edge 0, RX=0 only during the ACK slot (sampled at edge 2) -> TX=1 throughout; DONE pulse at edge 10; BUSY 0 at edge 13; all error flags remain 1.
- Transmitter, no ACK: RX=1 at edge 2 -> ACK_Error=0 from edge 2; TX=0 on edges 2–7; TX=1 on edges 8–15; IDLE at edge 16; DONE never asserted.
- Receiver, good CRC: ROLE=0, CRC_OK=1 -> TX=0 for the ACK slot bit only (set at edge 1); DONE at edge 10.
- Receiver, CRC fail: CRC_OK=0 -> TX stays 1 in the ACK slot; at edge 3 CRC_Error=0 and the error flag starts with TX=0 through edge 8; IDLE at edge 17.
- Bit errors and early IFS exit:
  - RX=0 at the CRC delimiter (edge 1) -> BIT_Error=0 and the error frame starts.
  - RX=0 at EOF bit 4 -> same error response.
  - RX=0 at IFS bit 1 -> IDLE with no error flag set.
- Reset and START handling:
  - reset=1 at edge 5 mid-EOF -> TX=1, BUSY=0, flags=1 after that edge.
  - START pulsed while BUSY=1 -> no effect.
  - A new START after an error frame -> flags clear to 1.
